// File: rtl/branch_unit_pkg.sv
// rtl/branch_unit_pkg.sv - shared types and constants for the branch unit
//
// Purpose: fetch-control state encoding and instruction size, shared by
// branch_unit and its sub-module.
package branch_unit_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } bu_state_e;

  localparam int INSTR_BYTES = 4;

  // Width of the bubble counter; it holds values up to FLUSH_CYCLES-1 (max 6).
  localparam int BUBBLE_W = 3;

endpackage

// File: rtl/branch_unit_bubble_counter.sv
// rtl/branch_unit_bubble_counter.sv - bubble counter used during a redirect flush
//
// Purpose: counts the remaining bubble cycles after a redirect.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   load         load load_val (takes priority over dec)
//   load_val     value to load
//   dec          decrement by one; has no effect once the count is zero
//   zero         count is zero
module bubble_counter
  import branch_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [BUBBLE_W-1:0] load_val,
  input  logic                dec,
  output logic                zero
);

  logic [BUBBLE_W-1:0] count_q;
  logic [BUBBLE_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - fetch PC sequencing with branch/jump redirect and flush
//
// Purpose: generates the fetch address, holds it on downstream stalls, and
// redirects to the execute-stage target with a fixed number of bubbles.
// Optional macro: BRANCH_UNIT_STATS_EN adds redirect_count and stall_cycles.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   ex_valid/ex_branch/ex_jump     execute-stage instruction qualifiers
//   take_branch, ex_target         branch decision and redirect target
//   stall, if_ready                hold request, fetch acceptance
//   pc, if_valid                   fetch address and fetch request
//   flush                          kill younger instructions (combinational)
//   misalign                       sticky misaligned-target flag
//   redirect_count, stall_cycles   statistics (only with BRANCH_UNIT_STATS_EN)
module branch_unit
  import branch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_branch,
  input  logic        ex_jump,
  input  logic        take_branch,
  input  logic [31:0] ex_target,
  input  logic        stall,
  input  logic        if_ready,
  output logic [31:0] pc,
  output logic        if_valid,
  output logic        flush,
  output logic        misalign
`ifdef BRANCH_UNIT_STATS_EN
  ,
  output logic [31:0] redirect_count,
  output logic [31:0] stall_cycles
`endif
);

  bu_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        misalign_q, misalign_d;
  logic        redirect;
  logic        cnt_load;
  logic        cnt_dec;
  logic        cnt_zero;

  assign redirect = ex_valid & (ex_jump | (ex_branch & take_branch));

  bubble_counter u_bubble_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (BUBBLE_W'(FLUSH_CYCLES - 1)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = misalign_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    if (redirect) begin
      // A redirect overrides stall, if_ready and any pending HOLD/FLUSH.
      state_d  = FLUSH;
      pc_d     = {ex_target[31:2], 2'b00};
      cnt_load = 1'b1;
      if (ex_target[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (if_ready) begin
            pc_d = pc_q + 32'(INSTR_BYTES);
          end
          if (stall) begin
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (!stall) begin
            state_d = RUN;
          end
        end
        FLUSH: begin
          if (cnt_zero) begin
            state_d = stall ? HOLD : RUN;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  // Gated with rst_n so nothing is requested or killed while reset is held.
  assign pc       = pc_q;
  assign if_valid = rst_n & (state_q == RUN);
  assign flush    = rst_n & redirect;
  assign misalign = misalign_q;

`ifdef BRANCH_UNIT_STATS_EN
  logic [31:0] redirect_count_q, redirect_count_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    redirect_count_d = redirect_count_q + {31'd0, redirect};
    stall_cycles_d   = stall_cycles_q + {31'd0, (state_q == HOLD)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_count_q <= '0;
      stall_cycles_q   <= '0;
    end else begin
      redirect_count_q <= redirect_count_d;
      stall_cycles_q   <= stall_cycles_d;
    end
  end

  assign redirect_count = redirect_count_q;
  assign stall_cycles   = stall_cycles_q;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// tb/tb_branch_unit.sv - scoreboard testbench for branch_unit
module tb_branch_unit;

  logic        clk;
  logic        rst_n;
  logic        ex_valid, ex_branch, ex_jump, take_branch;
  logic [31:0] ex_target;
  logic        stall, if_ready;
  logic [31:0] pc;
  logic        if_valid, flush, misalign;
`ifdef BRANCH_UNIT_STATS_EN
  logic [31:0] redirect_count, stall_cycles;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        if_valid;
    logic        flush;
    logic        misalign;
  } exp_t;

  exp_t exp_q[$];

  branch_unit #(
    .RESET_PC     (32'h0000_0100),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_valid    (ex_valid),
    .ex_branch   (ex_branch),
    .ex_jump     (ex_jump),
    .take_branch (take_branch),
    .ex_target   (ex_target),
    .stall       (stall),
    .if_ready    (if_ready),
    .pc          (pc),
    .if_valid    (if_valid),
    .flush       (flush),
    .misalign    (misalign)
`ifdef BRANCH_UNIT_STATS_EN
    ,
    .redirect_count (redirect_count),
    .stall_cycles   (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected entry per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests_run++;
        if (pc !== e.pc || if_valid !== e.if_valid || flush !== e.flush || misalign !== e.misalign) begin
          tests_failed++;
          $display("FAIL %s: got pc=%h if_valid=%b flush=%b misalign=%b, expected pc=%h if_valid=%b flush=%b misalign=%b",
                   e.name, pc, if_valid, flush, misalign, e.pc, e.if_valid, e.flush, e.misalign);
        end
      end
    end
  end

  // Drive one cycle of inputs just after the rising edge and queue the
  // expected outputs for that cycle.
  task automatic step(input string nm, input logic rst, input logic vld,
                      input logic br, input logic jmp, input logic tk,
                      input logic [31:0] tgt, input logic stl, input logic rdy,
                      input logic [31:0] e_pc, input logic e_iv,
                      input logic e_fl, input logic e_mis);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n       = rst;
    ex_valid    = vld;
    ex_branch   = br;
    ex_jump     = jmp;
    take_branch = tk;
    ex_target   = tgt;
    stall       = stl;
    if_ready    = rdy;
    e.name = nm; e.pc = e_pc; e.if_valid = e_iv; e.flush = e_fl; e.misalign = e_mis;
    exp_q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; ex_branch = 1'b0; ex_jump = 1'b0;
    take_branch = 1'b0; ex_target = '0; stall = 1'b0; if_ready = 1'b0;

    //    name              rst v b j t target         s r   pc            iv fl mis
    step("reset",           0, 0,0,0,0, 32'h0,         0,1, 32'h100,       0, 0, 0);
    step("run0",            1, 0,0,0,0, 32'h0,         0,1, 32'h100,       1, 0, 0);
    step("run1",            1, 0,0,0,0, 32'h0,         0,1, 32'h104,       1, 0, 0);
    step("run2",            1, 0,0,0,0, 32'h0,         0,1, 32'h108,       1, 0, 0);
    step("run3_notready",   1, 0,0,0,0, 32'h0,         0,0, 32'h10C,       1, 0, 0);
    step("pc_held",         1, 0,0,0,0, 32'h0,         0,0, 32'h10C,       1, 0, 0);
    step("br_not_taken",    1, 1,1,0,0, 32'h400,       0,1, 32'h10C,       1, 0, 0);
    step("nt_continue",     1, 0,0,0,0, 32'h0,         0,1, 32'h110,       1, 0, 0);
    step("jmp_200",         1, 1,0,1,0, 32'h200,       0,1, 32'h114,       1, 1, 0);
    step("bubble_a1",       1, 0,0,0,0, 32'h0,         0,1, 32'h200,       0, 0, 0);
    step("bubble_a2",       1, 0,0,0,0, 32'h0,         0,1, 32'h200,       0, 0, 0);
    step("br_taken_400",    1, 1,1,0,1, 32'h400,       0,1, 32'h200,       1, 1, 0);
    step("bubble_b1",       1, 0,0,0,0, 32'h0,         0,1, 32'h400,       0, 0, 0);
    step("bubble_b2",       1, 0,0,0,0, 32'h0,         0,1, 32'h400,       0, 0, 0);
    step("fetch_400",       1, 0,0,0,0, 32'h0,         0,1, 32'h400,       1, 0, 0);
    step("stall_run",       1, 0,0,0,0, 32'h0,         1,0, 32'h404,       1, 0, 0);
    step("hold",            1, 0,0,0,0, 32'h0,         1,1, 32'h404,       0, 0, 0);
    step("hold_release",    1, 0,0,0,0, 32'h0,         0,1, 32'h404,       0, 0, 0);
    step("resume",          1, 0,0,0,0, 32'h0,         0,1, 32'h404,       1, 0, 0);
    step("stall_and_jmp",   1, 1,0,1,0, 32'h80,        1,1, 32'h408,       1, 1, 0);
    step("jmp_in_flush",    1, 1,0,1,0, 32'hC0,        0,1, 32'h80,        0, 1, 0);
    step("bubble_c1",       1, 0,0,0,0, 32'h0,         0,1, 32'hC0,        0, 0, 0);
    step("bubble_c2_stall", 1, 0,0,0,0, 32'h0,         1,1, 32'hC0,        0, 0, 0);
    step("flush_to_hold",   1, 0,0,0,0, 32'h0,         0,1, 32'hC0,        0, 0, 0);
    step("jmp_top",         1, 1,0,1,0, 32'hFFFF_FFFC, 0,1, 32'hC0,        1, 1, 0);
    step("bubble_d1",       1, 0,0,0,0, 32'h0,         0,1, 32'hFFFF_FFFC, 0, 0, 0);
    step("bubble_d2",       1, 0,0,0,0, 32'h0,         0,1, 32'hFFFF_FFFC, 0, 0, 0);
    step("fetch_top",       1, 0,0,0,0, 32'h0,         0,1, 32'hFFFF_FFFC, 1, 0, 0);
    step("wrap_jmp_mis",    1, 1,0,1,0, 32'h3,         0,1, 32'h0,         1, 1, 0);
    step("mis_bubble1",     1, 0,0,0,0, 32'h0,         0,1, 32'h0,         0, 0, 1);
    step("mis_bubble2",     1, 0,0,0,0, 32'h0,         0,1, 32'h0,         0, 0, 1);
    step("mis_fetch",       1, 0,0,0,0, 32'h0,         0,1, 32'h0,         1, 0, 1);
    step("jmp_500",         1, 1,0,1,0, 32'h500,       0,1, 32'h4,         1, 1, 1);
    step("rst_mid_flush",   0, 1,0,1,0, 32'h600,       0,1, 32'h100,       0, 0, 0);
`ifdef BRANCH_UNIT_STATS_EN
    #1;
    tests_run++;
    if (redirect_count !== 32'd0) begin
      tests_failed++;
      $display("FAIL stats_reset: got redirect_count=%0d, expected 0", redirect_count);
    end
`endif
    step("first_after_rst", 1, 0,0,0,0, 32'h0,         0,1, 32'h100,       1, 0, 0);
    step("after_rst_next",  1, 0,0,0,0, 32'h0,         0,1, 32'h104,       1, 0, 0);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter FLUSH_CYCLES, default 2, legal range 1..7: bubbles emitted after a redirect.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 ex_valid  in  1  execute stage holds a valid instruction this cycle.
REQ-006 ex_branch  in  1  that instruction is a conditional branch.
REQ-007 ex_jump  in  1  that instruction is an unconditional jump.
REQ-008 take_branch  in  1  branch decision from the execute-stage ALU.
REQ-009 ex_target  in  32  redirect target (byte address).
REQ-010 stall  in  1  downstream hazard hold request.
REQ-011 if_ready  in  1  instruction memory accepts a fetch this cycle.
REQ-012 pc  out  32  current fetch address.
REQ-013 if_valid  out  1  pc is a real fetch request.
REQ-014 flush  out  1  kill younger instructions in fetch/decode this cycle.
REQ-015 misalign  out  1  sticky flag: a redirect target had target[1:0] != 0.

Function
REQ-016 States: RUN, HOLD, FLUSH; encoding is in the shared package.
REQ-017 Redirect condition = ex_valid & (ex_jump | (ex_branch & take_branch)).
REQ-018 RUN: if_valid=1; pc += 4 on each cycle with if_valid & if_ready; pc holds when if_ready=0.
REQ-019 RUN -> HOLD when stall=1 with no redirect; HOLD has if_valid=0, pc held; HOLD -> RUN when stall=0.
REQ-020 Redirect in any state, next edge: pc <= {ex_target[31:2],2'b00}, flush=1 combinationally in the redirect cycle, state -> FLUSH, bubble counter <= FLUSH_CYCLES-1.
REQ-021 Redirect wins over stall and over if_ready in the same cycle; an outstanding HOLD is discarded.
REQ-022 FLUSH: if_valid=0; counter decrements each cycle; at 0 -> HOLD if stall=1, else RUN.
REQ-023 Redirect during FLUSH restarts the sequence with the new target (latest redirect wins).
REQ-024 PC addition is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
REQ-025 misalign sets on a redirect with ex_target[1:0] != 0; clears only on reset.
REQ-026 Latency: redirect decision to first fetch of the target = FLUSH_CYCLES+1 edges when stall=0 and if_ready=1.

Reset
REQ-027 rst_n low asynchronously forces: pc=RESET_PC, state=RUN, counter=0, misalign=0; flush=0 and if_valid=0 while rst_n is low.
REQ-028 Reset asserted mid-FLUSH or mid-HOLD discards all pending redirect and stall state; the first fetch after release is RESET_PC.

Configuration
REQ-029 Macro BRANCH_UNIT_STATS_EN: when defined, adds outputs redirect_count[31:0] (counts redirects, wraps at 2^32) and stall_cycles[31:0] (counts HOLD cycles, wraps), both zeroed on reset; when undefined, those ports and counters do not exist and all other behaviour is identical.

Structure
REQ-030 Shared defines package holds the state enum type (RUN/HOLD/FLUSH) and the constant INSTR_BYTES=4.
REQ-031 One sub-module, bubble_counter (load/decrement/zero flag), is natural; the rest stays in branch_unit.

Verification
REQ-032 Reset release, RESET_PC=32'h100, if_ready=1 for 3 cycles -> pc 0x100, 0x104, 0x108, 0x10C; flush=0.
REQ-033 In RUN at pc=0x200, ex_branch=1, take_branch=1, ex_target=0x400, FLUSH_CYCLES=2 -> flush=1 that cycle, 2 cycles if_valid=0, then if_valid=1 with pc=0x400.
REQ-034 Same as REQ-033 but take_branch=0 -> no flush; pc continues 0x204.
REQ-035 stall=1 and ex_jump=1 (target 0x80) in the same cycle -> redirect taken, pc=0x80 after flush; HOLD is not entered.
REQ-036 pc=32'hFFFF_FFFC, if_ready=1 -> next pc=0; jump to 0x3 -> pc=0x0, misalign=1, remains 1 until rst_n low.
REQ-037 rst_n pulsed low during FLUSH counter=1 -> pc=RESET_PC immediately, flush=0, first fetch after release at RESET_PC; with BRANCH_UNIT_STATS_EN, redirect_count=0.
